// File: rtl/sqrt_pwl_eval.sv
// Four-stage square-root evaluator for the Box-Muller f = sqrt(e) path:
// range reduction, piecewise-linear segment, odd-exponent sqrt(2) fix-up, rescale and round.
module sqrt_pwl_eval #(
  parameter int E_W    = 31,
  parameter int E_FRAC = 24,
  parameter int F_W    = 16,
  parameter int F_FRAC = 12,
  parameter int ADDR_W = 6,
  parameter int C1_W   = 20,
  parameter int C0_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [E_W-1:0]    e_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [31:0]       coef_data,
  output logic [F_W-1:0]    f_out,
  output logic              valid_out,
  input  logic              ready_out
);

  localparam logic [15:0] SQRT2 = 16'hB505;
  localparam int OFF_W = E_FRAC - ADDR_W;
  localparam int LP_W  = $clog2(E_W);
  localparam int EXP_W = LP_W + 1;
  localparam int Y_W   = C1_W + 2;
  localparam int P_W   = C1_W + OFF_W;
  localparam int M_W   = Y_W + 16;
  localparam int R_W   = Y_W + 2;

  logic                    adv;
  logic [LP_W-1:0]         lead_pos;
  logic [E_W-1:0]          norm;
  logic signed [EXP_W-1:0] exp_d;
  logic [ADDR_W-1:0]       addr_d;
  logic [OFF_W-1:0]        off_d;

  logic                    v1_q, zero1_q;
  logic signed [EXP_W-1:0] exp1_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [OFF_W-1:0]        off1_q;

  logic                    v2_q, zero2_q;
  logic signed [EXP_W-1:0] exp2_q;
  logic [Y_W-1:0]          base, y2_d, y2_q;
  logic [P_W-1:0]          seg_prod;

  logic                    v3_q, zero3_q;
  logic signed [EXP_W-1:0] hexp3_q;
  logic [Y_W-1:0]          y3_d, y3_q;
  logic [M_W-1:0]          corr_prod;

  logic [EXP_W-1:0]        sh_amt;
  logic [R_W-1:0]          rnd;
  logic [F_W-1:0]          f_d, f_q;
  logic                    valid_q;

  assign adv       = !(valid_q && !ready_out);
  assign ready_in  = adv;
  assign coef_addr = addr_q;
  assign f_out     = f_q;
  assign valid_out = valid_q;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < E_W; i++) begin
      if (e_in[i]) lead_pos = LP_W'(i);
    end
    norm            = e_in << (LP_W'(E_W - 1) - lead_pos);
    exp_d           = EXP_W'(lead_pos) - EXP_W'(E_FRAC);
    {addr_d, off_d} = (ADDR_W + OFF_W)'(norm >> (E_W - 1 - ADDR_W - OFF_W));
  end

  // y is UQ1.C1_W: the intercept is widened so the slope product is added untruncated.
  always_comb begin
    base      = {1'b0, 1'b1, coef_data[C0_W-1:0], {(C1_W - C0_W){1'b0}}};
    seg_prod  = P_W'(coef_data[31 -: C1_W]) * P_W'(off1_q);
    y2_d      = base + Y_W'(seg_prod >> OFF_W);
    corr_prod = M_W'(y2_q) * M_W'(SQRT2);
    y3_d      = exp2_q[0] ? Y_W'(corr_prod >> 15) : y2_q;
  end

  // Combined shift: 2^floor(exp/2) and the UQ1.C1_W -> UQ4.F_FRAC realignment are always a right shift.
  always_comb begin
    sh_amt = EXP_W'(C1_W - F_FRAC) - hexp3_q;
    rnd    = (R_W'(y3_q) + (R_W'(1) << (sh_amt - EXP_W'(1)))) >> sh_amt;
    if (zero3_q)              f_d = '0;
    else if (|rnd[R_W-1:F_W]) f_d = '1;
    else                      f_d = rnd[F_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
  // NOTE: data registers are cleared with the valids so coef_addr and f_out leave reset at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      zero1_q <= 1'b0;
      exp1_q  <= '0;
      addr_q  <= '0;
      off1_q  <= '0;
      v2_q    <= 1'b0;
      zero2_q <= 1'b0;
      exp2_q  <= '0;
      y2_q    <= '0;
      v3_q    <= 1'b0;
      zero3_q <= 1'b0;
      hexp3_q <= '0;
      y3_q    <= '0;
      valid_q <= 1'b0;
      f_q     <= '0;
    end else if (adv) begin
      v1_q    <= valid_in;
      zero1_q <= (e_in == '0);
      exp1_q  <= exp_d;
      addr_q  <= addr_d;
      off1_q  <= off_d;
      v2_q    <= v1_q;
      zero2_q <= zero1_q;
      exp2_q  <= exp1_q;
      y2_q    <= y2_d;
      v3_q    <= v2_q;
      zero3_q <= zero2_q;
      hexp3_q <= exp2_q >>> 1;
      y3_q    <= y3_d;
      valid_q <= v3_q;
      if (v3_q) f_q <= f_d;
    end
  end

endmodule

// File: tb/tb_sqrt_pwl_eval.sv
// Bench for sqrt_pwl_eval: directed spec cases plus a random stream, scored against a
// real-arithmetic model of the segment evaluation and against true sqrt.
module tb_sqrt_pwl_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic [30:0] e_in;
  logic        valid_in, ready_in;
  logic [5:0]  coef_addr;
  logic [31:0] coef_data;
  logic [15:0] f_out;
  logic        valid_out, ready_out;

  logic [31:0] rom [64];
  logic [30:0] exp_q [$];
  logic [30:0] e_pop;
  int checks = 0;
  int errors = 0;

  sqrt_pwl_eval dut (
    .clk(clk), .reset(reset), .e_in(e_in), .valid_in(valid_in), .ready_in(ready_in),
    .coef_addr(coef_addr), .coef_data(coef_data), .f_out(f_out),
    .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;
  assign coef_data = rom[coef_addr];

  // Segment k covers [1+k/64, 1+(k+1)/64); C1 closes the chord from the rounded C0 to the segment end.
  task automatic build_rom();
    real x0, x1;
    int  c0, c1;
    logic [31:0] c0v, c1v;
    for (int k = 0; k < 64; k++) begin
      x0  = 1.0 + k / 64.0;
      x1  = 1.0 + (k + 1) / 64.0;
      c0  = int'($floor(($sqrt(x0) - 1.0) * 4096.0 + 0.5));
      c1  = int'($floor(($sqrt(x1) - 1.0 - c0 / 4096.0) * 1048576.0 + 0.5));
      c0v = 32'(c0);
      c1v = 32'(c1);
      rom[k] = {c1v[19:0], c0v[11:0]};
    end
  endtask

  // Exact-arithmetic evaluation of the algorithm with the ROM contents, in f_out LSBs.
  function automatic real ref_f(input logic [30:0] e);
    int p, k, ex;
    real m, pos, y;
    logic [31:0] w;
    if (e == 0) return 0.0;
    p = 0;
    for (int i = 0; i < 31; i++) if (e[i]) p = i;
    m   = real'(e) / (2.0 ** p);
    pos = (m - 1.0) * 64.0;
    k   = int'($floor(pos));
    w   = rom[k];
    y   = 1.0 + w[11:0] / 4096.0 + (w[31:12] / 1048576.0) * (pos - k);
    ex  = p - 24;
    if (ex % 2 != 0) y = y * $sqrt(2.0);
    return y * (2.0 ** $floor(ex / 2.0)) * 4096.0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs, input real ideal, input real tol);
    real d;
    logic ok;
    checks++;
    d  = real'(obs) - ideal;
    if (d < 0.0) d = -d;
    ok = !$isunknown(obs) && (d <= tol);
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %.2f +-%.1f", tag, obs, obs, ideal, tol);
    end
  endtask

  // Scoreboard: accepted inputs queue up; each delivered output must match the next one in order.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (valid_out && ready_out) begin
        check_eq("sb_output_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e_pop = exp_q.pop_front();
          check_near("sb_model", f_out, ref_f(e_pop), 1.0);
          if (e_pop < 31'h1000_0000) check_near("sb_sqrt", f_out, $sqrt(real'(e_pop)), 2.0);
        end
      end
      if (valid_in && ready_in) exp_q.push_back(e_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [30:0] e, output int lat, output logic [5:0] addr_s2);
    e_in     = e;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    addr_s2  = coef_addr;
    lat      = 1;
    while (valid_out !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, run, best;
    logic [5:0]  addr;
    logic [15:0] held;
    logic [30:0] e;

    reset = 1'b1; valid_in = 1'b0; e_in = '0; ready_out = 1'b1;
    build_rom();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check_eq("rst_f_out", {16'b0, f_out}, 32'd0);
    check_eq("rst_coef_addr", {26'b0, coef_addr}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_ready_in", {31'b0, ready_in}, 32'd1);
    tick();

    // Directed values
    send_one(31'h0100_0000, lat, addr);
    check_eq("lat_1p0", 32'(lat), 32'd4);
    check_eq("addr_1p0", {26'b0, addr}, 32'd0);
    check_near("f_1p0", f_out, 4096.0, 2.0);
    send_one(31'h0400_0000, lat, addr);
    check_near("f_4p0", f_out, 8192.0, 2.0);
    send_one(31'h0200_0000, lat, addr);
    check_near("f_2p0", f_out, 5793.0, 2.0);
    send_one(31'h0, lat, addr);
    check_eq("valid_zero", {31'b0, valid_out}, 32'd1);
    check_eq("f_zero", {16'b0, f_out}, 32'd0);
    send_one(31'h7FFF_FFFF, lat, addr);
    check_near("f_max", f_out, 46341.0, 2.0);
    send_one(31'h0180_0000, lat, addr);
    check_eq("addr_1p5", {26'b0, addr}, 32'd32);
    check_near("f_1p5", f_out, $sqrt(real'(32'h0180_0000)), 2.0);
    send_one(31'h1, lat, addr);
    check_near("f_min", f_out, 1.0, 2.0);
    send_one(31'h3, lat, addr);
    check_near("f_3lsb", f_out, $sqrt(3.0), 2.0);
    tick();

    // Back-to-back segment starts 1+k/64
    run = 0; best = 0;
    for (int c = 0; c < 72; c++) begin
      if (c < 64) begin
        valid_in = 1'b1;
        e_in     = 31'h0100_0000 + 31'(c) * 31'h0004_0000;
      end else begin
        valid_in = 1'b0;
      end
      tick();
      if (valid_out) run++;
      else run = 0;
      if (run > best) best = run;
    end
    check_eq("stream_run", 32'(best), 32'd64);

    // Downstream stall with input pending
    for (int c = 0; c < 6; c++) begin
      valid_in = 1'b1;
      e_in     = 31'($urandom >> $urandom_range(1, 31));
      tick();
    end
    check_eq("stall_pre_valid", {31'b0, valid_out}, 32'd1);
    ready_out = 1'b0;
    #1;
    check_eq("stall_ready_in0", {31'b0, ready_in}, 32'd0);
    held = f_out;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("stall_ready_in", {31'b0, ready_in}, 32'd0);
      check_eq("stall_hold", {16'b0, f_out}, {16'b0, held});
    end
    ready_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      e_in = 31'($urandom >> $urandom_range(1, 31));
      tick();
    end
    valid_in = 1'b0;
    repeat (10) tick();
    check_eq("stall_no_drop", 32'(exp_q.size()), 32'd0);

    // Reset with samples in flight
    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1;
      e_in     = 31'($urandom >> $urandom_range(1, 31));
      tick();
    end
    check_eq("rst_mid_pre_valid", {31'b0, valid_out}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_valid_out", {31'b0, valid_out}, 32'd0);
    check_eq("rst_mid_f_out", {16'b0, f_out}, 32'd0);
    valid_in = 1'b0;
    tick();
    reset = 1'b0;
    run = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid_out) run++;
    end
    check_eq("rst_mid_no_ghost", 32'(run), 32'd0);
    send_one(31'h0090_0000, lat, addr);
    check_eq("rst_mid_lat", 32'(lat), 32'd4);
    check_near("rst_mid_f", f_out, $sqrt(real'(32'h0090_0000)), 2.0);
    tick();

    // Random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      e         = 31'($urandom >> $urandom_range(1, 31));
      e_in      = e;
      ready_out = ($urandom_range(0, 3) != 0);
      tick();
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    repeat (12) tick();
    check_eq("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
